// File: rtl/tcdm_master_shim_if.sv
// Core-side valid/ready request/response bundle plus the network req/gnt/vld port of one TCDM master.
// Latency: none, this is wiring only.
// Backpressure: req_ready/resp_ready on the core side; gnt and the credit gate on the network side.
interface tcdm_master_shim_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    // core request / response
    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_add;
    logic                 req_wen;
    logic [DataWidth-1:0] req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DataWidth-1:0] resp_rdata;
    // network request / response
    logic                 req;
    logic                 gnt;
    logic [AddrWidth-1:0] add;
    logic                 wen;
    logic [DataWidth-1:0] wdata;
    logic                 vld;
    logic [DataWidth-1:0] rdata;
    logic                 err;

    // shim view
    modport slave (
        input  req_valid, req_add, req_wen, req_wdata, resp_ready, gnt, vld, rdata,
        output req_ready, resp_valid, resp_rdata, req, add, wen, wdata, err
    );

    // core + network environment view
    modport master (
        output req_valid, req_add, req_wen, req_wdata, resp_ready, gnt, vld, rdata,
        input  req_ready, resp_valid, resp_rdata, req, add, wen, wdata, err
    );
endinterface

// File: rtl/tcdm_master_shim.sv
// Core valid/ready to TCDM req/gnt front-end with outstanding-credit gate and response FIFO.
// Latency: accept -> req 1 cycle, gnt -> vld 1 cycle (network), vld -> resp_valid 1 cycle.
// Backpressure: request held stable until granted; req withheld when credits run out; responses buffered.
module tcdm_master_shim #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          WriteRespOn    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    tcdm_master_shim_if.slave bus
);
    localparam int unsigned          CntWidth = $clog2(MaxOutstanding) + 1;
    localparam int unsigned          PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(MaxOutstanding);
    localparam logic [PtrWidth-1:0]  PtrLast  = PtrWidth'(MaxOutstanding - 1);

    // holding register
    logic                 hold_vld_q;
    logic [AddrWidth-1:0] add_q;
    logic                 wen_q;
    logic [DataWidth-1:0] wdata_q;

    // credits: granted responses not yet popped by the core
    logic [CntWidth-1:0]  cnt_q;

    // response FIFO
    logic [DataWidth-1:0] mem_q [MaxOutstanding];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  fcnt_q;
    logic                 err_q;

    logic needs_cr;
    logic req;
    logic grant;
    logic rdy;
    logic accept;
    logic inc;
    logic dec;
    logic fifo_empty;
    logic fifo_full;
    logic bad_vld;
    logic push;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrWidth'(1);
    endfunction

    // Stores only take a credit when the network answers them.
    assign needs_cr   = !wen_q || WriteRespOn;
    assign req        = hold_vld_q && (!needs_cr || (cnt_q < CntMax));
    assign grant      = req && bus.gnt;
    assign rdy        = !hold_vld_q || grant;
    assign accept     = bus.req_valid && rdy;
    assign inc        = grant && needs_cr;
    assign fifo_empty = (fcnt_q == '0);
    assign fifo_full  = (fcnt_q == CntMax);
    assign dec        = !fifo_empty && bus.resp_ready;
    // A response with no credit outstanding, or with no room, is a protocol violation: drop it.
    assign bad_vld    = bus.vld && ((cnt_q == '0) || (fifo_full && !dec));
    assign push       = bus.vld && !bad_vld;

    assign bus.req_ready  = rdy;
    assign bus.req        = req;
    assign bus.add        = add_q;
    assign bus.wen        = wen_q;
    assign bus.wdata      = wdata_q;
    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_rdata = mem_q[rd_ptr_q];
    assign bus.err        = err_q;

    // Load a new request on accept; a grant without a new accept empties the register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_vld_q <= 1'b0;
            add_q      <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
        end else if (accept) begin
            hold_vld_q <= 1'b1;
            add_q      <= bus.req_add;
            wen_q      <= bus.req_wen;
            wdata_q    <= bus.req_wdata;
        end else if (grant) begin
            hold_vld_q <= 1'b0;
        end
    end

    // Credit counter: +1 per credited grant, -1 per core pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Response FIFO storage and pointers; push and pop may coincide, even when full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.rdata;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (dec) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, dec})
                2'b10:   fcnt_q <= fcnt_q + CntWidth'(1);
                2'b01:   fcnt_q <= fcnt_q - CntWidth'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // Sticky error flag for dropped responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (bad_vld) begin
            err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tcdm_master_shim.sv
// Directed bench for tcdm_master_shim: network responder model, response scoreboard, two DUT configurations.
// Latency: inputs driven 1 time unit after posedge, checks 4 units after posedge.
// Backpressure: core ready and network grant are driven per step by the stimulus.
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))

module tb_tcdm_master_shim;
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    int          errors    = 0;
    int          checks    = 0;
    int          g1        = 0;
    int          g2        = 0;
    bit          b2_seen   = 1'b0;
    bit          force_vld = 1'b0;
    logic        nxt_vld   = 1'b0;
    logic [31:0] nxt_rdata = '0;
    logic [31:0] exp_v;
    logic [31:0] sb_q [$];

    localparam logic [31:0] A1 = 32'h84F7_E4B5;

    tcdm_master_shim_if #(.AddrWidth(32), .DataWidth(32)) b1 ();
    tcdm_master_shim_if #(.AddrWidth(32), .DataWidth(32)) b2 ();

    tcdm_master_shim #(
        .AddrWidth(32), .DataWidth(32), .MaxOutstanding(4), .WriteRespOn(1'b1)
    ) dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (b1.slave)
    );

    tcdm_master_shim #(
        .AddrWidth(32), .DataWidth(32), .MaxOutstanding(4), .WriteRespOn(1'b0)
    ) dut2 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (b2.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Network model: every grant is answered one cycle later; loads return rd_model(add), stores 0.
    always @(negedge clk) begin
        nxt_vld   = 1'b0;
        nxt_rdata = '0;
        if (rst_n) begin
            if (b1.req && b1.gnt) begin
                nxt_vld   = 1'b1;
                nxt_rdata = b1.wen ? 32'h0 : rd_model(b1.add);
            end else if (force_vld) begin
                nxt_vld   = 1'b1;
                nxt_rdata = 32'hBAD0_0BAD;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        b1.vld   = nxt_vld;
        b1.rdata = nxt_rdata;
    end

    // Monitor: grant counting and in-order response scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b1.req && b1.gnt) g1++;
            if (b1.resp_valid && b1.resp_ready) begin
                if (sb_q.size() > 0) begin
                    exp_v = sb_q.pop_front();
                    checks++;
                    if (b1.resp_rdata !== exp_v) begin
                        errors++;
                        $error("FAIL resp_rdata observed=%0h expected=%0h", b1.resp_rdata, exp_v);
                    end
                end else begin
                    `CHK("resp_unexpected", b1.resp_valid, 0);
                end
            end
            if (b2.req && b2.gnt) g2++;
            if (b2.resp_valid) b2_seen = 1'b1;
        end
    end

    task automatic chk_reset(input string p);
        `CHK({p, "_req"}, b1.req, 0);
        `CHK({p, "_req_ready"}, b1.req_ready, 1);
        `CHK({p, "_resp_valid"}, b1.resp_valid, 0);
        `CHK({p, "_add"}, b1.add, 0);
        `CHK({p, "_wen"}, b1.wen, 0);
        `CHK({p, "_wdata"}, b1.wdata, 0);
        `CHK({p, "_resp_rdata"}, b1.resp_rdata, 0);
        `CHK({p, "_err"}, b1.err, 0);
        `CHK({p, "_cnt"}, dut1.cnt_q, 0);
    endtask

    // Present a request and wait (bounded) for it to be accepted; scoreboard entry on accept.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        int n;
        b1.req_valid = 1'b1;
        b1.req_add   = a;
        b1.req_wen   = w;
        b1.req_wdata = d;
        #3;
        n = 0;
        while (!b1.req_ready && n < 40) begin
            @(posedge clk);
            #4;
            n++;
        end
        `CHK("issue_ready", b1.req_ready, 1);
        if (b1.req_ready) sb_q.push_back(w ? 32'h0 : rd_model(a));
        cyc();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            cyc();
            n++;
        end
        cyc();
        #3;
        `CHK(tag, sb_q.size(), 0);
        `CHK({tag, "_cnt"}, dut1.cnt_q, 0);
        cyc();
    endtask

    // Single load with immediate grant: exact cycle-by-cycle latency and credit trace.
    task automatic run_single(input string p);
        b1.gnt        = 1'b1;
        b1.resp_ready = 1'b1;
        b1.req_valid  = 1'b1;
        b1.req_add    = A1;
        b1.req_wen    = 1'b0;
        b1.req_wdata  = '0;
        #3;
        `CHK({p, "_c0_ready"}, b1.req_ready, 1);
        `CHK({p, "_c0_req"}, b1.req, 0);
        sb_q.push_back(32'hDEAD_BEEF);
        cyc();
        b1.req_valid = 1'b0;
        #3;
        `CHK({p, "_c1_req"}, b1.req, 1);
        `CHK({p, "_c1_add"}, b1.add, A1);
        `CHK({p, "_c1_cnt"}, dut1.cnt_q, 0);
        cyc();
        #3;
        `CHK({p, "_c2_vld"}, b1.vld, 1);
        `CHK({p, "_c2_req"}, b1.req, 0);
        `CHK({p, "_c2_cnt"}, dut1.cnt_q, 1);
        `CHK({p, "_c2_resp_valid"}, b1.resp_valid, 0);
        cyc();
        #3;
        checks++;
        if (b1.resp_valid !== 1'b1) begin
            errors++;
            $error("FAIL %s_c3_resp_valid observed=%0h expected=1", p, b1.resp_valid);
        end
        checks++;
        if (b1.resp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $error("FAIL %s_c3_rdata observed=%0h expected=deadbeef", p, b1.resp_rdata);
        end
        `CHK({p, "_c3_cnt"}, dut1.cnt_q, 1);
        cyc();
        #3;
        `CHK({p, "_c4_cnt"}, dut1.cnt_q, 0);
        `CHK({p, "_c4_resp_valid"}, b1.resp_valid, 0);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b1.req_valid = 1'b0; b1.req_add = '0; b1.req_wen = 1'b0; b1.req_wdata = '0;
        b1.resp_ready = 1'b0; b1.gnt = 1'b0;
        b2.req_valid = 1'b0; b2.req_add = '0; b2.req_wen = 1'b0; b2.req_wdata = '0;
        b2.resp_ready = 1'b0; b2.gnt = 1'b1; b2.vld = 1'b0; b2.rdata = '0;

        // reset values
        #1 rst_n = 1'b0;
        #1;
        chk_reset("rst");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: single load, grant tied high
        run_single("t1");

        // 2: eight loads with core stalled, credits cap at 4
        b1.resp_ready = 1'b0;
        g1 = 0;
        for (int i = 0; i < 5; i++) issue(32'h1000 + 32'(i * 4), 1'b0, '0);
        b1.req_add = 32'h1014;
        for (int i = 0; i < 3; i++) begin
            #3;
            `CHK("t2_req_gated", b1.req, 0);
            `CHK("t2_ready_low", b1.req_ready, 0);
            `CHK("t2_add_stable", b1.add, 32'h1010);
            `CHK("t2_grants", g1, 4);
            `CHK("t2_cnt_max", dut1.cnt_q, 4);
            cyc();
        end
        b1.resp_ready = 1'b1;
        for (int i = 5; i < 8; i++) issue(32'h1000 + 32'(i * 4), 1'b0, '0);
        b1.req_valid = 1'b0;
        drain("t2_drain");
        `CHK("t2_total_grants", g1, 8);

        // 3: grant held low five cycles with request pending
        b1.gnt = 1'b0;
        issue(32'h2000, 1'b1, 32'hCAFE_0001);
        b1.req_valid = 1'b1; b1.req_add = 32'h2004; b1.req_wen = 1'b1; b1.req_wdata = 32'hCAFE_0002;
        for (int i = 0; i < 5; i++) begin
            #3;
            `CHK("t3_req", b1.req, 1);
            `CHK("t3_add", b1.add, 32'h2000);
            `CHK("t3_wdata", b1.wdata, 32'hCAFE_0001);
            `CHK("t3_wen", b1.wen, 1);
            `CHK("t3_ready_low", b1.req_ready, 0);
            cyc();
        end
        b1.gnt = 1'b1;
        #3;
        `CHK("t3_ready_on_gnt", b1.req_ready, 1);
        sb_q.push_back(32'h0);
        cyc();
        b1.req_valid = 1'b0;
        #3;
        `CHK("t3_next_add", b1.add, 32'h2004);
        `CHK("t3_next_wdata", b1.wdata, 32'hCAFE_0002);
        `CHK("t3_next_req", b1.req, 1);
        drain("t3_drain");

        // 4: stores without write responses never consume credits
        for (int i = 0; i < 10; i++) begin
            b2.req_valid = 1'b1;
            b2.req_add   = 32'h3000 + 32'(i * 4);
            b2.req_wen   = 1'b1;
            b2.req_wdata = 32'(i);
            #3;
            `CHK("t4_ready", b2.req_ready, 1);
            cyc();
        end
        b2.req_valid = 1'b0;
        cyc();
        cyc();
        #3;
        `CHK("t4_grants", g2, 10);
        `CHK("t4_cnt", dut2.cnt_q, 0);
        `CHK("t4_resp_seen", b2_seen, 0);
        `CHK("t4_err", b2.err, 0);
        cyc();

        // 5: spurious response with no credit outstanding
        `CHK("t5_cnt0", dut1.cnt_q, 0);
        force_vld = 1'b1;
        cyc();
        force_vld = 1'b0;
        #3;
        `CHK("t5_vld", b1.vld, 1);
        `CHK("t5_err_before", b1.err, 0);
        cyc();
        #3;
        checks++;
        if (b1.err !== 1'b1) begin
            errors++;
            $error("FAIL t5_err_set observed=%0h expected=1", b1.err);
        end
        checks++;
        if (b1.resp_valid !== 1'b0) begin
            errors++;
            $error("FAIL t5_fifo_empty observed=%0h expected=0", b1.resp_valid);
        end
        cyc();
        cyc();
        #3;
        checks++;
        if (b1.err !== 1'b1) begin
            errors++;
            $error("FAIL t5_err_sticky observed=%0h expected=1", b1.err);
        end
        `CHK("t5_fifo_still_empty", b1.resp_valid, 0);
        cyc();

        // 6: reset mid-burst with two in flight and one held
        b1.resp_ready = 1'b0;
        b1.gnt = 1'b1;
        issue(32'h4000, 1'b0, '0);
        issue(32'h4004, 1'b0, '0);
        issue(32'h4008, 1'b0, '0);
        b1.req_valid = 1'b0;
        b1.gnt = 1'b0;
        #1;
        `CHK("t6_pre_held", b1.req, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("t6_rst");
        sb_q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        run_single("t6");
        cyc();
        #3;
        `CHK("t6_err_after", b1.err, 0);
        `CHK("t6_sb_empty", sb_q.size(), 0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
